// File: rtl/chess_pkg.sv
// Shared definitions for the chess game clock: turn-sequencer state encoding,
// player encoding and generic on/off and true/false constants.
package chess_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WHITE_TURN = 2'd1,
    BLACK_TURN = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  localparam logic WHITE_PLAYER = 1'b1;
  localparam logic BLACK_PLAYER = 1'b0;

  localparam logic ON    = 1'b1;
  localparam logic OFF   = 1'b0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

endpackage

// File: rtl/second_prescaler.sv
// One-second prescaler for the game clock.
// Counts 0..CLOCK_FREQUENCY-1 while Enable is high and holds otherwise.
// Ports:
//   clock    in   system clock
//   resetApp in   asynchronous active-high reset
//   Enable   in   count this cycle
//   Clear    in   restart the second from zero (wins over Enable)
//   Tick     out  high in the cycle whose edge wraps the count back to zero
module second_prescaler
  import chess_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 50_000_000
) (
  input  logic clock,
  input  logic resetApp,
  input  logic Enable,
  input  logic Clear,
  output logic Tick
);

  localparam int unsigned CW = (CLOCK_FREQUENCY > 1) ? $clog2(CLOCK_FREQUENCY) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLOCK_FREQUENCY - 1);

  logic [CW-1:0] count;

  // Combinational so the owner can act on the wrap at the same edge the
  // count returns to zero; the owner registers its own tick output.
  assign Tick = (Enable == ON) && (count == LAST);

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      count <= '0;
    end else if (Clear) begin
      count <= '0;
    end else if (Enable) begin
      count <= Tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/chess_turn_timer.sv
// Turn sequencer and per-player game clock for the timed chess game.
// Ports:
//   clock         in   system clock
//   resetApp      in   asynchronous active-high reset
//   StartGame     in   pulse, starts/restarts a game from IDLE or GAME_OVER
//   PauseSwitch   in   level, freezes clocks and blocks moves
//   MoveDone      in   pulse, current player completed a legal move
//   KingCaptured  in   pulse, current player's move captured the opposing king
//   Player        out  side to move (1 = white, 0 = black)
//   WhiteSeconds  out  white's remaining seconds
//   BlackSeconds  out  black's remaining seconds
//   MoveEnable    out  board input may be accepted
//   GameOver      out  game has ended
//   Winner        out  winning side, valid while GameOver
//   SecondTick    out  one-cycle pulse per elapsed second of the active clock
module chess_turn_timer
  import chess_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY   = 50_000_000,
  parameter int unsigned START_SECONDS     = 300,
  parameter int unsigned INCREMENT_SECONDS = 0,
  parameter int unsigned TIME_WIDTH        = 10
) (
  input  logic                  clock,
  input  logic                  resetApp,
  input  logic                  StartGame,
  input  logic                  PauseSwitch,
  input  logic                  MoveDone,
  input  logic                  KingCaptured,
  output logic                  Player,
  output logic [TIME_WIDTH-1:0] WhiteSeconds,
  output logic [TIME_WIDTH-1:0] BlackSeconds,
  output logic                  MoveEnable,
  output logic                  GameOver,
  output logic                  Winner,
  output logic                  SecondTick
);

  localparam logic [TIME_WIDTH-1:0] START_T = TIME_WIDTH'(START_SECONDS);
  localparam longint unsigned       TMAX    = (64'd1 << TIME_WIDTH) - 64'd1;
  // Increment clamped to the counter range so the add below cannot lose a carry.
  localparam logic [TIME_WIDTH:0]   INC     = (INCREMENT_SECONDS > TMAX) ?
                                              (TIME_WIDTH+1)'(TMAX) :
                                              (TIME_WIDTH+1)'(INCREMENT_SECONDS);

  state_t                state;
  logic                  running;
  logic                  idle_like;
  logic                  tick;
  logic                  clear;
  logic                  timeout;
  logic [TIME_WIDTH-1:0] active_time;
  logic [TIME_WIDTH-1:0] dec_time;
  logic [TIME_WIDTH-1:0] inc_time;
  logic [TIME_WIDTH:0]   sum;

  assign running   = ((state == WHITE_TURN) || (state == BLACK_TURN)) && !PauseSwitch;
  assign idle_like = (state == IDLE) || (state == GAME_OVER);

  always_comb begin
    active_time = (Player == WHITE_PLAYER) ? WhiteSeconds : BlackSeconds;
    // A tick in the same cycle as a move is applied before the increment.
    dec_time    = (tick && (active_time != '0)) ? active_time - 1'b1 : active_time;
    sum         = {1'b0, dec_time} + INC;
    inc_time    = sum[TIME_WIDTH] ? '1 : sum[TIME_WIDTH-1:0];
    timeout     = tick && (active_time <= TIME_WIDTH'(1));
    clear       = (idle_like && StartGame) ||
                  (running && MoveDone && !timeout && !KingCaptured);
  end

  second_prescaler #(
    .CLOCK_FREQUENCY(CLOCK_FREQUENCY)
  ) u_prescaler (
    .clock   (clock),
    .resetApp(resetApp),
    .Enable  (running),
    .Clear   (clear),
    .Tick    (tick)
  );

  always_ff @(posedge clock or posedge resetApp) begin
    if (resetApp) begin
      state        <= IDLE;
      Player       <= WHITE_PLAYER;
      WhiteSeconds <= START_T;
      BlackSeconds <= START_T;
      MoveEnable   <= OFF;
      GameOver     <= FALSE;
      Winner       <= BLACK_PLAYER;
      SecondTick   <= OFF;
    end else begin
      SecondTick <= tick;
      case (state)
        IDLE, GAME_OVER: begin
          if (StartGame) begin
            state        <= WHITE_TURN;
            Player       <= WHITE_PLAYER;
            WhiteSeconds <= START_T;
            BlackSeconds <= START_T;
            GameOver     <= FALSE;
            Winner       <= BLACK_PLAYER;
            MoveEnable   <= !PauseSwitch;
          end
        end
        WHITE_TURN, BLACK_TURN: begin
          if (!running) begin
            MoveEnable <= OFF;
          end else if (timeout) begin
            // Final tick outranks any move in the same cycle.
            if (Player == WHITE_PLAYER) WhiteSeconds <= '0;
            else                        BlackSeconds <= '0;
            state      <= GAME_OVER;
            GameOver   <= TRUE;
            Winner     <= !Player;
            MoveEnable <= OFF;
          end else if (KingCaptured) begin
            if (Player == WHITE_PLAYER) WhiteSeconds <= dec_time;
            else                        BlackSeconds <= dec_time;
            state      <= GAME_OVER;
            GameOver   <= TRUE;
            Winner     <= Player;
            MoveEnable <= OFF;
          end else if (MoveDone) begin
            if (Player == WHITE_PLAYER) WhiteSeconds <= inc_time;
            else                        BlackSeconds <= inc_time;
            Player     <= !Player;
            state      <= (state == WHITE_TURN) ? BLACK_TURN : WHITE_TURN;
            MoveEnable <= ON;
          end else begin
            if (Player == WHITE_PLAYER) WhiteSeconds <= dec_time;
            else                        BlackSeconds <= dec_time;
            MoveEnable <= ON;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chess_turn_timer.sv
// Directed bench for chess_turn_timer with CLOCK_FREQUENCY=4, START_SECONDS=3,
// INCREMENT_SECONDS=1. Observed vector layout (25 bits, hex):
//   {Player, WhiteSeconds[9:0], BlackSeconds[9:0], MoveEnable, GameOver, Winner, SecondTick}
module tb_chess_turn_timer;

  logic       clock = 1'b0;
  logic       resetApp = 1'b0;
  logic       StartGame = 1'b0;
  logic       PauseSwitch = 1'b0;
  logic       MoveDone = 1'b0;
  logic       KingCaptured = 1'b0;
  logic       Player;
  logic [9:0] WhiteSeconds;
  logic [9:0] BlackSeconds;
  logic       MoveEnable;
  logic       GameOver;
  logic       Winner;
  logic       SecondTick;

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [24:0] obs;
  logic [24:0] exp;

  chess_turn_timer #(
    .CLOCK_FREQUENCY  (4),
    .START_SECONDS    (3),
    .INCREMENT_SECONDS(1),
    .TIME_WIDTH       (10)
  ) dut (
    .clock       (clock),
    .resetApp    (resetApp),
    .StartGame   (StartGame),
    .PauseSwitch (PauseSwitch),
    .MoveDone    (MoveDone),
    .KingCaptured(KingCaptured),
    .Player      (Player),
    .WhiteSeconds(WhiteSeconds),
    .BlackSeconds(BlackSeconds),
    .MoveEnable  (MoveEnable),
    .GameOver    (GameOver),
    .Winner      (Winner),
    .SecondTick  (SecondTick)
  );

  always #5 clock = ~clock;

  assign obs = {Player, WhiteSeconds, BlackSeconds, MoveEnable, GameOver, Winner, SecondTick};

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetApp = 1'b1;
    step();
    step();
    exp = {1'b1, 10'd3, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", obs, exp);
    end
    resetApp = 1'b0;
    step();
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL idle_after_release: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_start();
    StartGame = 1'b1;
    step();
    StartGame = 1'b0;
    exp = {1'b1, 10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL start_game: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_tick();
    for (int i = 1; i <= 3; i++) begin
      step();
      exp = {1'b1, 10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0};
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL pre_tick_%0d: got %h expected %h", i, obs, exp);
      end
    end
    step();
    exp = {1'b1, 10'd2, 10'd3, 1'b1, 1'b0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL first_tick: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_move();
    step();
    step();
    MoveDone = 1'b1;
    step();
    MoveDone = 1'b0;
    exp = {1'b0, 10'd3, 10'd2 + 10'd1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp = {1'b0, 10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL move_increment: got %h expected %h", obs, exp);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL black_pre_tick_%0d: got %h expected %h", i, obs, exp);
      end
    end
    step();
    exp = {1'b0, 10'd3, 10'd2, 1'b1, 1'b0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL black_tick_after_move: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_pause();
    step();
    step();
    PauseSwitch = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      MoveDone = (i == 5);
      step();
      MoveDone = 1'b0;
      exp = {1'b0, 10'd3, 10'd2, 1'b0, 1'b0, 1'b0, 1'b0};
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL paused_cycle_%0d: got %h expected %h", i, obs, exp);
      end
    end
    PauseSwitch = 1'b0;
    step();
    exp = {1'b0, 10'd3, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL resume_first: got %h expected %h", obs, exp);
    end
    step();
    exp = {1'b0, 10'd3, 10'd1, 1'b1, 1'b0, 1'b0, 1'b1};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL resume_held_prescaler: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_timeout();
    MoveDone = 1'b1;
    step();
    MoveDone = 1'b0;
    exp = {1'b1, 10'd3, 10'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL black_move: got %h expected %h", obs, exp);
    end
    for (int i = 1; i <= 11; i++) begin
      step();
      if (i == 4 || i == 8) begin
        exp = {1'b1, (i == 4) ? 10'd2 : 10'd1, 10'd2, 1'b1, 1'b0, 1'b0, 1'b1};
        tests++;
        if (obs !== exp) begin
          fails++;
          $display("FAIL white_idle_tick_%0d: got %h expected %h", i, obs, exp);
        end
      end
    end
    MoveDone = 1'b1;
    step();
    MoveDone = 1'b0;
    exp = {1'b1, 10'd0, 10'd2, 1'b0, 1'b1, 1'b0, 1'b1};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL timeout: got %h expected %h", obs, exp);
    end
    for (int i = 1; i <= 5; i++) step();
    exp = {1'b1, 10'd0, 10'd2, 1'b0, 1'b1, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL frozen_after_timeout: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_king_and_reset();
    StartGame = 1'b1;
    step();
    StartGame = 1'b0;
    exp = {1'b1, 10'd3, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL restart: got %h expected %h", obs, exp);
    end
    MoveDone = 1'b1;
    step();
    MoveDone = 1'b0;
    step();
    KingCaptured = 1'b1;
    MoveDone = 1'b1;
    step();
    KingCaptured = 1'b0;
    MoveDone = 1'b0;
    exp = {1'b0, 10'd4, 10'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL king_captured: got %h expected %h", obs, exp);
    end
    step();
    #2;
    resetApp = 1'b1;
    #1;
    exp = {1'b1, 10'd3, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL async_reset: got %h expected %h", obs, exp);
    end
    step();
    resetApp = 1'b0;
    step();
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL idle_after_reset: got %h expected %h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_tick();
    test_move();
    test_pause();
    test_timeout();
    test_king_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chess_turn_timer.md
# chess_turn_timer

Turn sequencer and per-player game clock for the timed chess game. It owns which player may move, gates the board-editing logic through `MoveEnable`, and counts down each player's remaining time while it is that player's turn. It switches turns on a move-completed pulse from the layout matrix logic and declares the game over on timeout or king capture. The display logic reads `Player`, the two time counts and the game-over outputs directly from this block.

## Interface
- `CLOCK_FREQUENCY`, default 50_000_000: `clock` cycles per second; the prescaler period.
- `START_SECONDS`, default 300: initial time loaded into each player's clock.
- `INCREMENT_SECONDS`, default 0: seconds added to the mover's clock on each completed move.
- `TIME_WIDTH`, default 10: width of each time counter; `START_SECONDS` must fit in it.

Ports:
- `clock`  in  1  system clock.
- `resetApp`  in  1  asynchronous, active-high reset.
- `StartGame`  in  1  single-cycle pulse; starts or restarts a game.
- `PauseSwitch`  in  1  level; high freezes clocks and blocks moves.
- `MoveDone`  in  1  single-cycle pulse from the layout logic; the current player completed a legal move.
- `KingCaptured`  in  1  single-cycle pulse; the current player's move captured the opposing king.
- `Player`  out  1  side to move; 1 = white, 0 = black.
- `WhiteSeconds`  out  TIME_WIDTH  white's remaining seconds.
- `BlackSeconds`  out  TIME_WIDTH  black's remaining seconds.
- `MoveEnable`  out  1  high when board input may be accepted.
- `GameOver`  out  1  high once the game has ended.
- `Winner`  out  1  winning side, valid while `GameOver` is high.
- `SecondTick`  out  1  one-cycle pulse on each elapsed second of the active clock.

## Operation
- **States**
  - IDLE (reset state).
  - WHITE_TURN, BLACK_TURN.
  - GAME_OVER.
- **Reset values**
  - State IDLE, prescaler 0.
  - `Player`=1; `WhiteSeconds` and `BlackSeconds` = `START_SECONDS`.
  - `MoveEnable`=0, `GameOver`=0, `Winner`=0, `SecondTick`=0.
- **IDLE or GAME_OVER + `StartGame`:**
  - Reload both clocks to `START_SECONDS`, clear the prescaler.
  - `Player`=1, `GameOver`=0, go to WHITE_TURN.
  - `StartGame` while in a turn state is ignored.
- **Running condition:** in a turn state with `PauseSwitch` low.
  - Only while running does the prescaler count 0..`CLOCK_FREQUENCY`-1.
  - The count wrapping to 0 asserts `SecondTick` and decrements the active player's clock.
- **Paused:** prescaler, clocks and state are held; `MoveEnable`=0; `MoveDone` and `KingCaptured` are ignored.
- **`MoveDone` while running:**
  - Add `INCREMENT_SECONDS` to the mover's clock, saturating at 2^`TIME_WIDTH`-1.
  - Toggle `Player`, switch turn state, clear the prescaler so the next turn starts with a full second.
- **`KingCaptured` while running:** go to GAME_OVER with `Winner`=`Player`; the clocks are not incremented.
- **Timeout:** a tick that decrements the active clock from 1 to 0 goes to GAME_OVER with `Winner`=opposite of `Player`. Clocks saturate at 0 and never wrap.
- **Simultaneous events**, in priority order:
  - `resetApp` wins over everything.
  - The timeout tick wins over `MoveDone` and `KingCaptured` in the same cycle: the move is ignored and the timed-out player loses.
  - `KingCaptured` wins over `MoveDone`.
  - A non-final tick and `MoveDone` in the same cycle: decrement first, then add the increment, then switch.
- **`MoveEnable`** is 1 only in WHITE_TURN or BLACK_TURN with `PauseSwitch` low.
- **GAME_OVER:** all clocks frozen; `Player` holds its last value.

## Timing
- All outputs are registered.
- One cycle of latency from a sampled input to the outputs:
  - `MoveDone` at edge N gives the new `Player` and incremented time after edge N.
  - `StartGame` at edge N gives `MoveEnable`=1 after edge N.
- `SecondTick` rises exactly `CLOCK_FREQUENCY` running cycles after turn start or the previous tick; paused cycles do not count.
- `PauseSwitch` takes effect on the next edge; `MoveEnable` falls one cycle after `PauseSwitch` rises.
- `resetApp` asserted mid-game forces all outputs to their reset values asynchronously; operation resumes on the first edge after release.

## Structure
- **Shared package `chess_pkg`:**
  - State enum (IDLE, WHITE_TURN, BLACK_TURN, GAME_OVER).
  - `WHITE_PLAYER`=1'b1, `BLACK_PLAYER`=1'b0.
  - `ON`/`OFF`, `TRUE`/`FALSE`.
- **Sub-module `second_prescaler`:**
  - Parameter `CLOCK_FREQUENCY`; inputs `clock`, `resetApp`, `Enable`, `Clear`; output `Tick`.
  - Counter width is $clog2(`CLOCK_FREQUENCY`).

## Test plan
All scenarios use `CLOCK_FREQUENCY`=4, `START_SECONDS`=3, `INCREMENT_SECONDS`=1.

1. Reset, then `StartGame` pulse -> next cycle WHITE_TURN, `Player`=1, `MoveEnable`=1, both times 3, `GameOver`=0.
2. Run 4 cycles -> one `SecondTick` pulse, `WhiteSeconds`=2, `BlackSeconds`=3.
3. `MoveDone` 2 cycles into a second -> `WhiteSeconds`+1, `Player`=0, prescaler cleared; `BlackSeconds` reaches 2 exactly 4 cycles later.
4. `PauseSwitch` high for 10 cycles mid-turn, with a `MoveDone` pulse during the pause -> times unchanged, `MoveEnable`=0, `Player` unchanged; counting resumes with the prescaler at its held value.
5. White idles 12 running cycles -> `WhiteSeconds`=0, `GameOver`=1, `Winner`=0, `MoveEnable`=0; a `MoveDone` in the final-tick cycle is ignored, and further cycles keep the times frozen.
6. Black's turn with `KingCaptured` and `MoveDone` in the same cycle -> GAME_OVER, `Winner`=0, no increment. Then assert `resetApp` mid-game -> all outputs return to reset values immediately.
